// File: rtl/sram1_arb_pkg.sv
// sram1_arb_pkg: shared types and constants for the sram1 two-master arbiter.
//   sram_req_t : one master's request payload (byte address, byte write
//                enables, write data, byte read enables)
//   ID_M0/ID_M1: master identifiers held in the read owner register
package sram1_arb_pkg;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  we;
        logic [31:0] wd;
        logic [3:0]  re;
    } sram_req_t;

    localparam logic ID_M0 = 1'b0;
    localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/sram1_arb.sv
// sram1_arb: shares the single-port data SRAM between master 0 (core
// load/store, fixed priority) and master 1 (boot loader / debug DMA).
// One request is granted per cycle. The winning request is registered
// onto the SRAM port, and read data is routed back to its owner one
// cycle later. A wait counter forces a master 1 grant after MAX_WAIT
// cycles of denial.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   mX_req / mX_gnt          request valid / combinational grant
//   mX_a, mX_we, mX_wd, mX_re  byte address, byte write enables, write data,
//                            byte read enables
//   mX_rd, mX_rvld           read data (always sram_rd), read data valid
//   sram_a/_we/_wd/_re       registered SRAM word address and controls
//   sram_rd                  SRAM read data for the registered request
module sram1_arb
    import sram1_arb_pkg::*;
#(
    parameter int unsigned ADDR_W   = 8,
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    output logic              m0_gnt,
    input  logic [15:0]       m0_a,
    input  logic [3:0]        m0_we,
    input  logic [31:0]       m0_wd,
    input  logic [3:0]        m0_re,
    output logic [31:0]       m0_rd,
    output logic              m0_rvld,

    input  logic              m1_req,
    output logic              m1_gnt,
    input  logic [15:0]       m1_a,
    input  logic [3:0]        m1_we,
    input  logic [31:0]       m1_wd,
    input  logic [3:0]        m1_re,
    output logic [31:0]       m1_rd,
    output logic              m1_rvld,

    output logic [ADDR_W-1:0] sram_a,
    output logic [3:0]        sram_we,
    output logic [31:0]       sram_wd,
    output logic [3:0]        sram_re,
    input  logic [31:0]       sram_rd
);

    localparam logic [3:0] WMAX = 4'(MAX_WAIT);

    sram_req_t  m0_r;
    sram_req_t  m1_r;
    sram_req_t  win;
    logic       win_id;
    logic       m1_win;
    logic       any_gnt;
    logic       win_wr;
    logic       win_rd;
    logic [3:0] wcnt;
    logic       own_v;
    logic       own_id;

    // Byte-offset and out-of-range address bits are not used by a word SRAM.
    logic       unused_addr_bits;

    assign m0_r = {m0_a, m0_we, m0_wd, m0_re};
    assign m1_r = {m1_a, m1_we, m1_wd, m1_re};

    always_comb begin
        m1_win  = m1_req && (!m0_req || wcnt == WMAX);
        m1_gnt  = m1_win;
        m0_gnt  = m0_req && !m1_win;
        any_gnt = m0_gnt || m1_gnt;
        win     = m1_win ? m1_r : m0_r;
        win_id  = m1_win ? ID_M1 : ID_M0;
        win_wr  = win.we != '0;
        // A write wins over a simultaneous read; such a request returns no data.
        win_rd  = any_gnt && !win_wr && (win.re != '0);
    end

    assign unused_addr_bits = ^{win.a[15:ADDR_W+2], win.a[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            sram_a  <= '0;
            sram_we <= '0;
            sram_wd <= '0;
            sram_re <= '0;
            wcnt    <= '0;
            own_v   <= 1'b0;
            own_id  <= ID_M0;
        end else begin
            if (any_gnt) begin
                sram_a  <= win.a[ADDR_W+1:2];
                sram_we <= win.we;
                sram_wd <= win.wd;
                sram_re <= win_wr ? '0 : win.re;
            end else begin
                // Address and write data hold; only the strobes drop.
                sram_we <= '0;
                sram_re <= '0;
            end

            if (m1_req && !m1_gnt) begin
                if (wcnt != WMAX) begin
                    wcnt <= wcnt + 4'd1;
                end
            end else begin
                wcnt <= '0;
            end

            own_v  <= win_rd;
            own_id <= win_id;
        end
    end

    assign m0_rd   = sram_rd;
    assign m1_rd   = sram_rd;
    assign m0_rvld = own_v && (own_id == ID_M0);
    assign m1_rvld = own_v && (own_id == ID_M1);

endmodule
